mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the instruction/data memory arbiter.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Saturation value of the 2-bit starvation counter
  localparam logic [1:0] STARVE_SAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between the fetch (I) and data (D) stages.
// D normally wins, but a pending fetch is guaranteed a slot after STARVE_MAX
// consecutive D grants. Commands are registered at grant and held until ack.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int AW         = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_abort,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t state;
  logic [1:0] starve_cnt;
  logic       abort_seen;
  logic       i_cand;
  logic       d_cand;
  logic       starve_ok;
  logic       grant_i;
  logic       grant_d;

  // Arbitration decision, only meaningful while idle
  always_comb begin
    i_cand    = i_req & ~i_ready & ~i_abort;
    d_cand    = d_req & ~d_ready;
    starve_ok = ({30'd0, starve_cnt} < STARVE_MAX);
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state == ST_IDLE) begin
      if (d_cand && (!i_req || starve_ok)) begin
        grant_d = 1'b1;
      end else if (i_cand) begin
        grant_i = 1'b1;
      end else begin
        grant_i = 1'b0;
      end
    end else begin
      grant_d = 1'b0;
    end
  end

  // Stall requests are derived from live requests and the registered ready pulses
  always_comb begin
    stall_if  = i_req & ~i_ready & ~i_abort;
    stall_mem = d_req & ~d_ready;
  end

  // Starvation counter: counts D grants that bypassed a waiting fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 2'd0;
    end else if (grant_d && i_req) begin
      if (starve_cnt != STARVE_SAT) begin
        starve_cnt <= starve_cnt + 2'd1;
      end else begin
        starve_cnt <= starve_cnt;
      end
    end else if ((state == ST_IDLE) && (grant_i || !i_req)) begin
      starve_cnt <= 2'd0;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Arbiter FSM: issues the registered command, waits for ack, returns data
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      abort_seen <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          abort_seen <= 1'b0;
          if (grant_d) begin
            state     <= ST_D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state     <= ST_I_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_I_BUSY: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            // A squashed fetch still completes on the bus but is not delivered
            if (!(abort_seen || i_abort)) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              i_rdata <= i_rdata;
            end
          end else if (i_abort) begin
            abort_seen <= 1'b1;
          end else begin
            abort_seen <= abort_seen;
          end
        end
        ST_D_BUSY: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            // Stores complete without touching the load data register
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
          end else begin
            state <= ST_D_BUSY;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
